// File: rtl/priority_arb_seq.sv
// Registered N-channel priority arbiter: fixed (highest index wins) or round-robin,
// grant held until ack. Optional grant_onehot output enabled by PRIO_ARB_ONEHOT_EN.
module priority_arb_seq #(
  parameter int N_CH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0]           req,
  input  logic                      rr_mode,
  input  logic                      ack,
  output logic [$clog2(N_CH)-1:0]   grant_idx,
  output logic                      grant_valid,
  output logic [7:0]                busy_cnt
`ifdef PRIO_ARB_ONEHOT_EN
  ,
  output logic [N_CH-1:0]           grant_onehot
`endif
);

  localparam int IDX_W = $clog2(N_CH);

  // Handshake: grant_valid/grant_idx are held stable until ack is seen while
  // grant_valid=1; ack with grant_valid=0 is ignored; a grant is never revoked.
  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   last_idx, last_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic               valid_nxt;
  logic [7:0]         busy_nxt;
  logic [IDX_W-1:0]   base, start;
  logic [IDX_W-1:0]   win_all, win_lo, winner;
  logic               found_lo;

  // On an ack cycle the search is based on the grant being retired right now.
  always_comb begin
    base = (state == GRANT && ack) ? grant_idx : last_idx;
    if (!rr_mode || base == '0) start = IDX_W'(N_CH - 1);
    else                        start = base - 1'b1;
  end

  // Descending search from start with wrap: the highest set bit at or below
  // start wins; failing that, the highest set bit above start.
  always_comb begin
    win_all  = '0;
    win_lo   = '0;
    found_lo = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (req[k]) begin
        win_all = IDX_W'(k);
        if (k <= int'(start)) begin
          win_lo   = IDX_W'(k);
          found_lo = 1'b1;
        end
      end
    end
    winner = found_lo ? win_lo : win_all;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = grant_idx;
    valid_nxt = grant_valid;
    busy_nxt  = busy_cnt;
    last_nxt  = last_idx;
    case (state)
      IDLE: begin
        busy_nxt  = 8'd0;
        valid_nxt = 1'b0;
        if (|req) begin
          idx_nxt   = winner;
          valid_nxt = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          last_nxt = grant_idx;
          busy_nxt = 8'd0;
          if (|req) begin
            idx_nxt   = winner;
            valid_nxt = 1'b1;
          end else begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end else begin
          busy_nxt = (busy_cnt == 8'hFF) ? busy_cnt : busy_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        busy_nxt  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      busy_cnt    <= 8'd0;
      last_idx    <= '0;
    end else begin
      state       <= state_nxt;
      grant_idx   <= idx_nxt;
      grant_valid <= valid_nxt;
      busy_cnt    <= busy_nxt;
      last_idx    <= last_nxt;
    end
  end

`ifdef PRIO_ARB_ONEHOT_EN
  logic [N_CH-1:0] onehot_nxt;

  always_comb begin
    onehot_nxt = '0;
    if (valid_nxt) onehot_nxt = N_CH'(1) << idx_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) grant_onehot <= '0;
    else        grant_onehot <= onehot_nxt;
  end
`endif

endmodule

// File: tb/tb_priority_arb_seq.sv
// Directed bench for priority_arb_seq: an 8-channel and a 5-channel instance
// sharing clock and reset, expected grant indices queued at stimulus time.
module tb_priority_arb_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] req8 = '0;
  logic       rr8 = 1'b0, ack8 = 1'b0;
  logic [2:0] idx8;
  logic       valid8;
  logic [7:0] busy8;

  logic [4:0] req5 = '0;
  logic       rr5 = 1'b0, ack5 = 1'b0;
  logic [2:0] idx5;
  logic       valid5;
  logic [7:0] busy5;

`ifdef PRIO_ARB_ONEHOT_EN
  logic [7:0] onehot8;
  logic [4:0] onehot5;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  priority_arb_seq #(.N_CH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .rr_mode(rr8), .ack(ack8),
    .grant_idx(idx8), .grant_valid(valid8), .busy_cnt(busy8)
`ifdef PRIO_ARB_ONEHOT_EN
    , .grant_onehot(onehot8)
`endif
  );

  priority_arb_seq #(.N_CH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .rr_mode(rr5), .ack(ack5),
    .grant_idx(idx5), .grant_valid(valid5), .busy_cnt(busy5)
`ifdef PRIO_ARB_ONEHOT_EN
    , .grant_onehot(onehot5)
`endif
  );

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check_pop(input string tag, input logic [31:0] obs);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=%0h expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, {24'd0, e});
    end
  endtask

  logic [7:0] rr8_seq [9];
  logic [7:0] rr5_seq [6];

  initial begin
    rr8_seq = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd7};
    rr5_seq = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd4};

    // Reset and idle
    tick();
    check("rst_valid", valid8, 0);
    check("rst_idx", idx8, 0);
    check("rst_busy", busy8, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_valid", valid8, 0);
      check("idle_idx", idx8, 0);
      check("idle_busy", busy8, 0);
    end

    // Fixed priority: highest index wins, held until ack
    req8 = 8'b0010_0101;
    push(8'd5);
    tick();
    check("fix_valid", valid8, 1);
    check_pop("fix_idx", idx8);
`ifdef PRIO_ARB_ONEHOT_EN
    check("fix_onehot", onehot8, 8'h20);
`endif
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("hold_idx", idx8, 5);
      check("hold_busy", busy8, i);
    end
    ack8 = 1'b1;
    push(8'd5);
    tick();
    check_pop("b2b_idx", idx8);
    check("b2b_valid", valid8, 1);
    check("b2b_busy", busy8, 0);
    req8 = 8'h00;
    tick();
    check("ack_idle_valid", valid8, 0);
    tick();
    check("ack_ignored_valid", valid8, 0);
    check("idle_busy2", busy8, 0);
    ack8 = 1'b0;

    // Round-robin from a fresh reset: 7..0 then wrap to 7
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rr8 = 1'b1;
    req8 = 8'hFF;
    ack8 = 1'b1;
    for (int i = 0; i < 9; i++) push(rr8_seq[i]);
    for (int i = 0; i < 9; i++) begin
      tick();
      check_pop("rr8_idx", idx8);
      check("rr8_valid", valid8, 1);
    end

    // Grant 3 (7 just acked, so search starts at 6), then drop req and hold
    req8 = 8'h08;
    tick();
    check("drop_idx", idx8, 3);
    ack8 = 1'b0;
    req8 = 8'h00;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("drop_hold_idx", idx8, 3);
      check("drop_hold_valid", valid8, 1);
    end
    ack8 = 1'b1;
    tick();
    check("drop_release_valid", valid8, 0);
    check("drop_release_busy", busy8, 0);
    ack8 = 1'b0;

    // Async reset between edges while granting 6
    rr8 = 1'b0;
    req8 = 8'h40;
    tick();
    check("pre_rst_idx", idx8, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", valid8, 0);
    check("async_rst_idx", idx8, 0);
    check("async_rst_busy", busy8, 0);
    #1;
    req8 = 8'h41;
    rst_n = 1'b1;
    tick();
    check("post_rst_idx", idx8, 6);
    check("post_rst_valid", valid8, 1);
    req8 = 8'h00;

    // N_CH=5: busy saturation
    req5 = 5'h01;
    tick();
    check("n5_first_idx", idx5, 0);
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254) check("n5_busy_254", busy5, 254);
      if (i == 300) check("n5_busy_sat", busy5, 255);
    end
    check("n5_hold_idx", idx5, 0);

    // N_CH=5 round-robin with wrap modulo 5
    rr5 = 1'b1;
    req5 = 5'h1F;
    ack5 = 1'b1;
    for (int i = 0; i < 6; i++) push(rr5_seq[i]);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_pop("rr5_idx", idx5);
      check("rr5_range", {31'd0, idx5 < 3'd5}, 1);
      check("rr5_valid", valid5, 1);
    end
    ack5 = 1'b0;
    req5 = '0;

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/priority_arb_seq.md
Name: priority_arb_seq

Overview:
- Registered, parametrised N-channel priority arbiter; successor to the 4:2 combinational priority encoder in the data processing unit.
- Selects one active request, issues a registered grant index with a valid flag, and holds it until the consumer acknowledges.
- Supports fixed-priority mode (highest index wins, same as the 4:2 encoder) and round-robin mode, selectable at run time.
- Sits between the request sources and the data-path mux select of the data processing unit.

Parameters:
- N_CH, 8, number of request channels; must be 2..64.
- IDX_W, derived localparam = $clog2(N_CH), width of the grant index; not user-settable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_CH  request vector; bit k = channel k requesting.
- rr_mode  input  1  0 = fixed priority, 1 = round-robin.
- ack  input  1  consumer accepts the current grant.
- grant_idx  output  IDX_W  index of the granted channel (registered).
- grant_valid  output  1  grant_idx is valid (registered).
- busy_cnt  output  8  saturating count of cycles the current grant has waited for ack.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - grant_idx = 0, grant_valid = 0, busy_cnt = 0.
  - last_idx = 0, state = IDLE.
  - Effect is immediate, including mid-grant.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If req != 0, arbitrate on this cycle's req.
  - Next edge: grant_idx = winner, grant_valid = 1, state = GRANT. Latency from req to grant_valid is 1 cycle.
  - If req == 0, stay in IDLE with grant_valid = 0.
- GRANT:
  - grant_idx and grant_valid are held stable until ack = 1.
  - A grant is never revoked, even if the granted req bit drops.
- On ack in GRANT:
  - last_idx = grant_idx.
  - If req != 0 in the same cycle, re-arbitrate with last_idx already updated. The new grant appears next edge with grant_valid kept at 1, giving back-to-back grants at 1 grant per cycle.
  - If req == 0, go to IDLE with grant_valid = 0 next edge.
  - req is sampled in the ack cycle, so it may include the channel just acknowledged.
- ack while grant_valid = 0 is ignored.
- Fixed mode: winner = highest set index of req.
- Round-robin mode:
  - Search starts at (last_idx - 1) mod N_CH and descends with wrap-around; the first set bit wins.
  - The just-granted channel therefore has lowest priority next time.
  - Reset value last_idx = 0 means the first search starts at N_CH-1, identical to fixed mode.
- last_idx updates only on ack, in both modes.
- A change to rr_mode takes effect at the next arbitration and never alters a held grant.
- busy_cnt:
  - Clears to 0 on every new grant.
  - Increments each GRANT cycle without ack and saturates at 255.
  - Reads 0 in IDLE.
- N_CH not a power of 2: grant_idx never exceeds N_CH-1; wrap-around is modulo N_CH, not 2^IDX_W.

Optional Feature:
- Macro PRIO_ARB_ONEHOT_EN.
- Defined: adds output grant_onehot [N_CH-1:0].
  - Registered, equals (1 << grant_idx) when grant_valid = 1, else all zeros.
  - Reset value is all zeros.
- Undefined: the port does not exist and behaviour is otherwise identical.

Test Plan:
- Reset/idle: rst_n = 0 then 1, req = 8'h00 for 5 cycles -> grant_valid = 0, grant_idx = 0, busy_cnt = 0 throughout.
- Fixed priority, N_CH = 8, rr_mode = 0:
  - req = 8'b0010_0101 -> 1 cycle later grant_idx = 5, grant_valid = 1.
  - Hold ack = 0 for 3 cycles -> grant_idx stays 5, busy_cnt = 3.
  - ack = 1 with req unchanged -> grant_idx = 5 again next cycle.
- Round-robin: rr_mode = 1, req = 8'hFF, ack = 1 every cycle -> grant_idx sequence 7, 6, 5, 4, 3, 2, 1, 0, 7, with grant_valid constantly 1.
- Grant hold on req drop: grant_idx = 3 active, req bit 3 drops to 0, ack = 0 for 2 cycles -> grant_idx stays 3 and grant_valid stays 1; on ack with req = 0 -> grant_valid = 0 next cycle.
- Async reset mid-grant: grant_valid = 1, grant_idx = 6, assert rst_n = 0 between clock edges -> outputs go to 0 immediately. After release with req = 8'h41 -> grant_idx = 6.
- Saturation and non-power-of-2: with N_CH = 5, hold ack = 0 for 300 cycles -> busy_cnt = 255. With rr_mode = 1, req = 5'h1F, acks each cycle -> sequence 4, 3, 2, 1, 0, 4; grant_idx never reaches 5..7.
